// File: rtl/deal_pkg.sv
// Shared types for the blackjack round controller: FSM states, result codes, defaults.
// Pure declarations, no timing or flow-control behaviour of its own.
package deal_pkg;

  localparam int DEF_BANK_STAND = 17;
  localparam int DEF_LIMIT      = 21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_DEAL_P1,
    ST_DEAL_B1,
    ST_DEAL_P2,
    ST_DEAL_B2,
    ST_PLAYER,
    ST_P_DRAW,
    ST_BANK,
    ST_B_DRAW,
    ST_JUDGE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_WIN,
    RES_LOSE,
    RES_DRAW
  } result_t;

  // Card counters stick at 7 rather than wrapping.
  function automatic logic [2:0] sat_inc3(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

endpackage

// File: rtl/deal_scheduler_hand_judge.sv
// Combinational round judge: hand totals plus natural flag in, result code out.
// Zero latency, no flow control.
module hand_judge
  import deal_pkg::*;
#(
  parameter int TOTAL_W = 7,
  parameter int LIMIT   = DEF_LIMIT
) (
  input  logic [TOTAL_W-1:0] i_p_total,
  input  logic [TOTAL_W-1:0] i_b_total,
  input  logic               i_natural,
  output logic [1:0]         o_result
);

  localparam logic [TOTAL_W-1:0] L_LIMIT = TOTAL_W'(LIMIT);

  always_comb begin
    o_result = RES_DRAW;
    if (i_p_total > L_LIMIT) begin
      o_result = RES_LOSE;
    end else if (i_natural) begin
      o_result = (i_b_total == L_LIMIT) ? RES_DRAW : RES_WIN;
    end else if (i_b_total > L_LIMIT) begin
      o_result = RES_WIN;
    end else if (i_p_total > i_b_total) begin
      o_result = RES_WIN;
    end else if (i_p_total < i_b_total) begin
      o_result = RES_LOSE;
    end
  end

endmodule

// File: rtl/deal_scheduler.sv
// Blackjack round sequencer: deals P,B,P,B, runs player turns and bank draw-to-stand, judges.
// card_ack is combinational on card_valid in draw states; a stalled source holds the state indefinitely.
module deal_scheduler
  import deal_pkg::*;
#(
  parameter int TOTAL_W    = 7,
  parameter int BANK_STAND = DEF_BANK_STAND,
  parameter int LIMIT      = DEF_LIMIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               stay,
  input  logic               card_valid,
  input  logic [3:0]         card_value,
  output logic               card_ack,
  output logic               p_load,
  output logic               b_load,
  output logic [3:0]         card_out,
  output logic               hand_clr,
  input  logic [TOTAL_W-1:0] p_total,
  input  logic [TOTAL_W-1:0] b_total,
  output logic [2:0]         p_cards,
  output logic [2:0]         b_cards,
  output logic               busy,
  output logic               win,
  output logic               lose,
  output logic               draw
);

  localparam logic [TOTAL_W-1:0] L_LIMIT = TOTAL_W'(LIMIT);
  localparam logic [TOTAL_W-1:0] L_STAND = TOTAL_W'(BANK_STAND);

  state_t     r_state;
  logic [2:0] r_p_cards;
  logic [2:0] r_b_cards;
  logic       r_busy;
  logic       r_win;
  logic       r_lose;
  logic       r_draw;

  logic       w_draw_st;
  logic       w_to_p;
  logic       w_natural;
  logic [1:0] w_result;

  always_comb begin
    w_draw_st = 1'b0;
    w_to_p    = 1'b0;
    case (r_state)
      ST_DEAL_P1, ST_DEAL_P2, ST_P_DRAW: begin
        w_draw_st = 1'b1;
        w_to_p    = 1'b1;
      end
      ST_DEAL_B1, ST_DEAL_B2, ST_B_DRAW: w_draw_st = 1'b1;
      default: ;
    endcase
  end

  assign card_ack = w_draw_st & card_valid;
  assign p_load   = card_ack & w_to_p;
  assign b_load   = card_ack & ~w_to_p;
  assign card_out = card_value;
  assign hand_clr = (r_state == ST_CLR);

  // Only a two-card 21 counts as a natural; later 21s are ordinary totals.
  assign w_natural = (r_p_cards == 3'd2) && (p_total == L_LIMIT);

  hand_judge #(
    .TOTAL_W (TOTAL_W),
    .LIMIT   (LIMIT)
  ) u_judge (
    .i_p_total (p_total),
    .i_b_total (b_total),
    .i_natural (w_natural),
    .o_result  (w_result)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_p_cards <= 3'd0;
      r_b_cards <= 3'd0;
      r_busy    <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
      r_draw    <= 1'b0;
    end else begin
      if (card_ack) begin
        if (w_to_p) r_p_cards <= sat_inc3(r_p_cards);
        else        r_b_cards <= sat_inc3(r_b_cards);
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_CLR;
            r_p_cards <= 3'd0;
            r_b_cards <= 3'd0;
            r_busy    <= 1'b1;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
            r_draw    <= 1'b0;
          end
        end
        ST_CLR:     r_state <= ST_DEAL_P1;
        ST_DEAL_P1: if (card_valid) r_state <= ST_DEAL_B1;
        ST_DEAL_B1: if (card_valid) r_state <= ST_DEAL_P2;
        ST_DEAL_P2: if (card_valid) r_state <= ST_DEAL_B2;
        ST_DEAL_B2: if (card_valid) r_state <= ST_PLAYER;
        ST_PLAYER: begin
          if (w_natural || (p_total > L_LIMIT)) r_state <= ST_JUDGE;
          else if (stay)                        r_state <= ST_BANK;
          else if (hit)                         r_state <= ST_P_DRAW;
        end
        ST_P_DRAW:  if (card_valid) r_state <= ST_PLAYER;
        ST_BANK:    r_state <= (b_total < L_STAND) ? ST_B_DRAW : ST_JUDGE;
        ST_B_DRAW:  if (card_valid) r_state <= ST_BANK;
        ST_JUDGE: begin
          r_win   <= (w_result == RES_WIN);
          r_lose  <= (w_result == RES_LOSE);
          r_draw  <= (w_result == RES_DRAW);
          r_busy  <= 1'b0;
          r_state <= ST_DONE;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign p_cards = r_p_cards;
  assign b_cards = r_b_cards;
  assign busy    = r_busy;
  assign win     = r_win;
  assign lose    = r_lose;
  assign draw    = r_draw;

endmodule

// File: doc/deal_scheduler.md
Name: deal_scheduler

Overview:
- Sequencing controller for one blackjack round.
- Owns the single shared card source and grants each card to either the player hand or the bank hand.
- Drives the initial four-card deal (P, B, P, B), player hit/stay turns, and the bank's draw-to-17 loop.
- Judges the result from the hand totals supplied by the hand datapath (ace-adjusting accumulators) and raises win/lose/draw, which also gates the bank display decoders.

Parameters:
- TOTAL_W, 7, width of the hand-total inputs.
- BANK_STAND, 17, bank stops drawing when its total is at or above this value.
- LIMIT, 21, bust threshold and natural-blackjack value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a round from IDLE or DONE.
- hit  in  1  one-cycle pulse; player requests a card.
- stay  in  1  one-cycle pulse; player ends their turn.
- card_valid  in  1  shared card source has a card ready.
- card_value  in  4  card rank, 1..10 (1 = ace).
- card_ack  out  1  card consumed this cycle.
- p_load  out  1  add card_out to the player hand this cycle.
- b_load  out  1  add card_out to the bank hand this cycle.
- card_out  out  4  card_value passthrough.
- hand_clr  out  1  clear both hand accumulators.
- p_total  in  TOTAL_W  player hand total; updated the cycle after p_load.
- b_total  in  TOTAL_W  bank hand total; updated the cycle after b_load.
- p_cards  out  3  number of cards dealt to the player.
- b_cards  out  3  number of cards dealt to the bank.
- busy  out  1  a round is in progress.
- win  out  1  registered result flag.
- lose  out  1  registered result flag.
- draw  out  1  registered result flag.

Behaviour:
- Reset (rst=0 at a clock edge) takes priority over everything, including mid-round operation:
  - state goes to IDLE;
  - win, lose, draw, busy, p_cards and b_cards are 0;
  - card_ack, p_load, b_load and hand_clr are 0.
- States: IDLE, CLR, DEAL_P1, DEAL_B1, DEAL_P2, DEAL_B2, PLAYER, P_DRAW, BANK, B_DRAW, JUDGE, DONE.
- IDLE or DONE with start=1:
  - go to CLR;
  - clear win, lose, draw and both card counters;
  - set busy=1.
- CLR: hand_clr=1 for exactly one cycle, then go to DEAL_P1.
- Draw states (DEAL_*, P_DRAW, B_DRAW):
  - card_ack = card_valid, combinational.
  - p_load or b_load equals card_ack, according to the target hand; card_out = card_value.
  - The state holds while card_valid=0, with no timeout.
  - On a handshake, the target card counter increments (saturating at 7) and the state advances: DEAL_P1→DEAL_B1→DEAL_P2→DEAL_B2→PLAYER; P_DRAW→PLAYER; B_DRAW→BANK.
- Every evaluating state is entered at least one cycle after the last load, so totals are always current when they are compared.
- PLAYER, priority order:
  1. p_cards=2 and p_total=LIMIT (natural) → JUDGE.
  2. p_total>LIMIT → JUDGE (lose).
  3. stay=1 → BANK; stay wins if it arrives together with hit.
  4. hit=1 → P_DRAW.
- Hit or stay in any other state is ignored and not queued. Start during busy=1 is ignored.
- BANK:
  - b_total<BANK_STAND → B_DRAW;
  - otherwise → JUDGE.
- JUDGE (one cycle), first match wins:
  1. p_total>LIMIT → lose.
  2. Natural player: b_total=LIMIT → draw, else win.
  3. b_total>LIMIT → win.
  4. p_total>b_total → win.
  5. p_total<b_total → lose.
  6. Otherwise → draw.
  - The flag is registered on entry to DONE; exactly one flag is set.
- A player bust never triggers bank draws; the bank keeps its two cards.
- DONE: busy=0; flags and counters hold until start or reset.
- Totals are compared as unsigned TOTAL_W values; no other arithmetic is performed here.

Decomposition:
- Shared package deal_pkg:
  - state enumeration (4-bit encoding);
  - BANK_STAND and LIMIT defaults;
  - result encoding: NONE, WIN, LOSE, DRAW.
- One sub-module, hand_judge: combinational; takes p_total, b_total and a natural flag, and outputs the result code. It is reused by the bench as a reference model.

Test Plan:
- Reset mid-round: rst=0 while in P_DRAW → next cycle IDLE, all outputs 0; a later card_valid=1 gives card_ack=0.
- Deal with a stalling source: start, card_valid toggles 1,0,1,1,1 → exactly 4 acks; loads go P,B,P,B; p_cards=2, b_cards=2; state PLAYER.
- Player natural: deal 1,5,10,9 (p_total=21, b_total=14 from the datapath) → win=1 with no bank draw; b_cards stays 2.
- Player bust: deal 10,7,5,9, then hit with card 8 (p_total=23) → lose=1, b_cards=2; a stay pulse afterwards is ignored.
- Bank draw loop: deal 10,6,8,4 (b_total=10), stay, bank receives 3 then 5 (b_total=18) → stops at 18 with b_cards=4; p_total=18 gives draw=1.
- hit and stay asserted in the same cycle in PLAYER → BANK entered, no p_load, p_cards unchanged.
